// File: rtl/ternary_requant.sv
// Requantizes signed accumulators (round, shift, ReLU, saturate) into an int8 stream with end-of-vector tags.
// Latency: 2 cycles from accepted input to out_valid when the FIFO is empty; one input per cycle sustained.
// Backpressure: out_ready stalls the OUT_LEN-deep FIFO; a result arriving at a full FIFO with no pop is dropped and overflow sticks.
module ternary_requant #(
   parameter int OUT_LEN   = 8,
   parameter int ACC_WIDTH = 12,
   parameter int OUT_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic                        cfg_load,
   input  logic [3:0]                  cfg_shift,
   input  logic                        cfg_relu,
   input  logic                        acc_valid,
   input  logic signed [ACC_WIDTH-1:0] acc_in,
   input  logic                        acc_last,
   output logic signed [OUT_WIDTH-1:0] out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic                        busy,
   output logic                        overflow
);

   localparam int IW = $clog2(OUT_LEN);
   localparam int CW = IW + 1;
   localparam int EW = ACC_WIDTH + 1;
   localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (OUT_WIDTH - 1)) - 1);
   localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic {IDLE, FRAME} state_t;

   logic [3:0]                  shift_q;
   logic                        relu_q;
   logic                        acc_take;
   logic [IW-1:0]               idx_q;
   logic                        tag_last;
   state_t                      state_q, state_d;

   logic signed [EW-1:0]        ext, rnd, sum, shr, rl;
   logic signed [OUT_WIDTH-1:0] res;

   logic                        stg_vld_q;
   logic signed [OUT_WIDTH-1:0] stg_dat_q;
   logic                        stg_last_q;

   logic [OUT_WIDTH:0]          mem [OUT_LEN];
   logic [IW-1:0]               wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]               cnt_q;
   logic                        fifo_full, push, pop, drop;

   assign acc_take  = acc_valid & en;
   assign tag_last  = (idx_q == IW'(OUT_LEN - 1)) | acc_last;
   assign out_valid = (cnt_q != '0);
   assign fifo_full = (cnt_q == CW'(OUT_LEN));
   assign pop       = out_valid & out_ready;
   assign push      = stg_vld_q & (~fifo_full | pop);
   assign drop      = stg_vld_q & fifo_full & ~pop;
   assign busy      = (state_q != IDLE) | stg_vld_q | out_valid;

   // Config registers; shift is clamped at load so the datapath never shifts past the sign bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_q <= '0;
         relu_q  <= 1'b0;
      end else if (cfg_load && !busy) begin
         shift_q <= (int'(cfg_shift) > ACC_WIDTH - 1) ? 4'(ACC_WIDTH - 1) : cfg_shift;
         relu_q  <= cfg_relu;
      end
   end

   // Round-half-up shift, ReLU and saturation on the incoming accumulator.
   always_comb begin
      ext = {acc_in[ACC_WIDTH-1], acc_in};
      rnd = '0;
      if (shift_q != 4'd0) rnd = EW'(1) << (shift_q - 4'd1);
      sum = ext + rnd;
      shr = sum >>> shift_q;
      rl  = (relu_q && shr[EW-1]) ? '0 : shr;
      if (rl > SAT_MAX)      res = SAT_MAX[OUT_WIDTH-1:0];
      else if (rl < SAT_MIN) res = SAT_MIN[OUT_WIDTH-1:0];
      else                   res = rl[OUT_WIDTH-1:0];
   end

   // Element index and frame state advance on every accepted input, even if its result is later dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q   <= '0;
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
         if (acc_take) idx_q <= tag_last ? '0 : idx_q + IW'(1);
      end
   end

   // Frame state: leave IDLE on a non-final element, return on the final one.
   always_comb begin
      state_d = state_q;
      if (acc_take) begin
         case (state_q)
            IDLE:    if (!tag_last) state_d = FRAME;
            FRAME:   if (tag_last)  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Single pipeline stage holding the requantized result and its tag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stg_vld_q  <= 1'b0;
         stg_dat_q  <= '0;
         stg_last_q <= 1'b0;
      end else begin
         stg_vld_q <= acc_take;
         if (acc_take) begin
            stg_dat_q  <= res;
            stg_last_q <= tag_last;
         end
      end
   end

   // FIFO storage; contents need no reset because pointers and count do.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {stg_last_q, stg_dat_q};
   end

   // FIFO pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + IW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + IW'(1);
         if (push && !pop)      cnt_q <= cnt_q + CW'(1);
         else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      end
   end

   // Registered FIFO head; holds its value when the FIFO empties.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data <= '0;
         out_last <= 1'b0;
      end else if (pop) begin
         if (cnt_q > CW'(1)) {out_last, out_data} <= mem[rd_ptr_q + IW'(1)];
         else if (push)      {out_last, out_data} <= {stg_last_q, stg_dat_q};
      end else if (push && cnt_q == '0) begin
         {out_last, out_data} <= {stg_last_q, stg_dat_q};
      end
   end

   // Sticky overflow flag for results lost to a full FIFO.
   always_ff @(posedge clk) begin
      if (!rst_n)    overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
   end

endmodule

// File: tb/tb_ternary_requant.sv
// Directed bench for ternary_requant: hand-computed vectors checked against a popped-output queue.
// Inputs change 1ns after the rising edge; pops are recorded on the falling edge.
// Each scenario starts from reset and drains the FIFO before checking.
module tb_ternary_requant;

   logic              clk = 1'b0;
   logic              rst_n, en, cfg_load, cfg_relu, acc_valid, acc_last, out_ready;
   logic [3:0]        cfg_shift;
   logic signed [11:0] acc_in;
   logic signed [7:0] out_data;
   logic              out_valid, out_last, busy, overflow;

   int n_chk  = 0;
   int n_fail = 0;
   int q_dat[$];
   int q_lst[$];

   ternary_requant dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cfg_load(cfg_load), .cfg_shift(cfg_shift),
      .cfg_relu(cfg_relu), .acc_valid(acc_valid), .acc_in(acc_in), .acc_last(acc_last),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Record every accepted output beat.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         q_dat.push_back(int'(out_data));
         q_lst.push_back(int'(out_last));
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      acc_valid = 1'b0; acc_last = 1'b0; en = 1'b1; cfg_load = 1'b0; out_ready = 1'b1;
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      q_dat.delete();
      q_lst.delete();
   endtask

   task automatic cfg(input int sh, input bit rl);
      cfg_shift = 4'(sh);
      cfg_relu  = rl;
      cfg_load  = 1'b1;
      tick();
      cfg_load  = 1'b0;
   endtask

   task automatic send(input int v, input bit lst);
      acc_valid = 1'b1;
      acc_in    = 12'(v);
      acc_last  = lst;
      tick();
      acc_last  = 1'b0;
   endtask

   task automatic expect_pop(input string tag, input int exp_d, input int exp_l);
      if (q_dat.size() == 0) begin
         chk({tag, "_missing"}, -999, exp_d);
      end else begin
         chk({tag, "_dat"}, q_dat.pop_front(), exp_d);
         chk({tag, "_lst"}, q_lst.pop_front(), exp_l);
      end
   endtask

   initial begin
      cfg_shift = '0; cfg_relu = 1'b0; acc_in = '0;
      do_reset();
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_last", int'(out_last), 0);

      // Rounding and latency
      cfg(2, 0);
      acc_valid = 1'b1; acc_in = 12'sd10;
      tick();
      chk("lat_n1_valid", int'(out_valid), 0);
      acc_in = -12'sd10;
      tick();
      chk("lat_n2_valid", int'(out_valid), 1);
      chk("lat_n2_data", int'(out_data), 3);
      acc_in = 12'sd5;
      tick();
      acc_in = -12'sd6;
      tick();
      acc_valid = 1'b0;
      drain(6);
      chk("rnd_count", q_dat.size(), 4);
      expect_pop("rnd0", 3, 0);
      expect_pop("rnd1", -2, 0);
      expect_pop("rnd2", 1, 0);
      expect_pop("rnd3", -1, 0);

      // ReLU with saturation
      do_reset();
      cfg(0, 1);
      send(2047, 0); send(-2048, 0); send(-1, 0); send(127, 0);
      acc_valid = 1'b0;
      drain(6);
      expect_pop("relu0", 127, 0);
      expect_pop("relu1", 0, 0);
      expect_pop("relu2", 0, 0);
      expect_pop("relu3", 127, 0);

      // Saturation without ReLU
      do_reset();
      cfg(0, 0);
      send(2047, 0); send(-2048, 0); send(-1, 0); send(127, 0);
      acc_valid = 1'b0;
      drain(6);
      expect_pop("sat0", 127, 0);
      expect_pop("sat1", -128, 0);
      expect_pop("sat2", -1, 0);
      expect_pop("sat3", 127, 0);

      // Shift clamped to 11
      do_reset();
      cfg(15, 0);
      send(2047, 0); send(-2048, 0);
      acc_valid = 1'b0;
      drain(6);
      expect_pop("clamp_pos", 1, 0);
      expect_pop("clamp_neg", -1, 0);

      // Full-length vector framing
      do_reset();
      cfg(0, 0);
      for (int i = 1; i <= 8; i++) send(i, 0);
      acc_valid = 1'b0;
      chk("frame_busy_mid", int'(busy), 1);
      drain(8);
      chk("frame_count", q_dat.size(), 8);
      for (int i = 1; i <= 8; i++) expect_pop($sformatf("frame%0d", i), i, (i == 8) ? 1 : 0);
      chk("frame_busy_end", int'(busy), 0);

      // acc_last on the 3rd element, then a fresh 8-element vector
      for (int i = 10; i <= 20; i++) send(i, i == 12);
      acc_valid = 1'b0;
      drain(8);
      chk("early_count", q_dat.size(), 11);
      for (int i = 10; i <= 20; i++)
         expect_pop($sformatf("early%0d", i), i, (i == 12 || i == 20) ? 1 : 0);

      // Overflow: 9 inputs into a blocked 8-deep FIFO
      do_reset();
      cfg(0, 0);
      out_ready = 1'b0;
      for (int i = 1; i <= 9; i++) send(i, 0);
      acc_valid = 1'b0;
      drain(3);
      chk("ovf_flag", int'(overflow), 1);
      chk("ovf_valid", int'(out_valid), 1);
      out_ready = 1'b1;
      drain(10);
      chk("ovf_count", q_dat.size(), 8);
      for (int i = 1; i <= 8; i++) expect_pop($sformatf("ovf%0d", i), i, (i == 8) ? 1 : 0);
      chk("ovf_sticky", int'(overflow), 1);

      // Full FIFO with simultaneous pop and push
      do_reset();
      cfg(0, 0);
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) send(i, 0);
      acc_valid = 1'b0;
      drain(3);
      chk("hold_data_a", int'(out_data), 1);
      tick();
      chk("hold_data_b", int'(out_data), 1);
      send(9, 0);
      acc_valid = 1'b0;
      out_ready = 1'b1;
      drain(12);
      chk("popush_ovf", int'(overflow), 0);
      chk("popush_count", q_dat.size(), 9);
      for (int i = 1; i <= 9; i++) expect_pop($sformatf("popush%0d", i), i, (i == 8) ? 1 : 0);

      // cfg_load ignored while busy; en=0 ignores inputs
      do_reset();
      cfg(1, 0);
      send(4, 0); send(5, 0); send(6, 0); send(7, 0);
      acc_valid = 1'b0;
      cfg(3, 0);
      send(16, 0);
      en = 1'b0; acc_in = 12'sd100;
      tick(); tick();
      en = 1'b1;
      send(2, 0); send(4, 0); send(6, 0);
      acc_valid = 1'b0;
      drain(8);
      chk("gate_count", q_dat.size(), 8);
      expect_pop("gate0", 2, 0);
      expect_pop("gate1", 3, 0);
      expect_pop("gate2", 3, 0);
      expect_pop("gate3", 4, 0);
      expect_pop("gate4", 8, 0);
      expect_pop("gate5", 1, 0);
      expect_pop("gate6", 2, 0);
      expect_pop("gate7", 3, 1);

      // Reset mid-vector
      do_reset();
      cfg(2, 0);
      out_ready = 1'b0;
      send(40, 0); send(41, 0); send(42, 0); send(43, 0);
      acc_valid = 1'b0;
      drain(2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      q_dat.delete(); q_lst.delete();
      chk("mrst_valid", int'(out_valid), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_overflow", int'(overflow), 0);
      send(5, 0);
      for (int i = 1; i <= 7; i++) send(i, 0);
      acc_valid = 1'b0;
      drain(8);
      chk("mrst_count", q_dat.size(), 8);
      expect_pop("mrst0", 5, 0);
      for (int i = 1; i <= 7; i++) expect_pop($sformatf("mrst%0d", i), i, (i == 7) ? 1 : 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
